// File: rtl/lc3_fetch_seq.sv
// LC-3 instruction-fetch sequencer: single-outstanding memory read, IR capture,
// PC increment/redirect via ld_pc/pc_sel. Optional abort timer: FETCH_TIMEOUT_EN.
module lc3_fetch_seq #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic        fetch_start,
  input  logic        redirect_valid,
  input  logic        redirect_sel,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  output logic        ld_pc,
  output logic [1:0]  pc_sel,
  output logic [15:0] ir,
  output logic        ir_valid,
  output logic        redirect_ack,
  output logic        busy,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_REDIR = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] mem_addr_q;
  logic [15:0] ir_q;
  logic        redir_sel_q;
  logic        to_hit;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          fetch_err_q;

  // Hit on the last allowed WAIT cycle; mem_ready in that cycle still wins.
  assign to_hit = (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      fetch_err_q <= (state == S_WAIT) && !mem_ready && to_hit;
      if (state != S_WAIT)
        to_cnt <= '0;
      else if (!mem_ready)
        to_cnt <= to_cnt + 1'b1;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  // No abort path: WAIT holds until the memory answers.
  assign to_hit    = (TIMEOUT_CYCLES < 0);
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (redirect_valid)   state_nxt = S_REDIR;
        else if (fetch_start) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready)   state_nxt = S_DONE;
        else if (to_hit) state_nxt = S_IDLE;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_REDIR: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mem_addr_q  <= 16'h0000;
      ir_q        <= 16'h0000;
      redir_sel_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && !redirect_valid && fetch_start)
        mem_addr_q <= pc;
      if (state == S_IDLE && redirect_valid)
        redir_sel_q <= redirect_sel;
      if (state == S_WAIT && mem_ready)
        ir_q <= mem_rdata;
    end
  end

  // Moore outputs decoded from state and captured registers only.
  assign mem_en       = (state == S_WAIT);
  assign mem_addr     = mem_addr_q;
  assign ld_pc        = (state == S_DONE) || (state == S_REDIR);
  assign pc_sel       = (state == S_REDIR) ? {redir_sel_q, ~redir_sel_q} : 2'b00;
  assign ir           = ir_q;
  assign ir_valid     = (state == S_DONE);
  assign redirect_ack = (state == S_REDIR);
  assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_lc3_fetch_seq.sv
// Randomized bench for lc3_fetch_seq: PC-block and memory environment plus an
// architectural model (program counter, last instruction) checked per transaction.
module tb_lc3_fetch_seq;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic        fetch_start, redirect_valid, redirect_sel, mem_ready;
  logic [15:0] mem_rdata;
  logic        mem_en, ld_pc, ir_valid, redirect_ack, busy, fetch_err;
  logic [15:0] mem_addr, ir;
  logic [1:0]  pc_sel;

  logic        env_init;
  logic [15:0] bus_val, ea_val;
  logic [15:0] arch_pc, last_ir;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  lc3_fetch_seq #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .fetch_start(fetch_start),
    .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_en(mem_en),
    .mem_addr(mem_addr), .ld_pc(ld_pc), .pc_sel(pc_sel), .ir(ir),
    .ir_valid(ir_valid), .redirect_ack(redirect_ack), .busy(busy),
    .fetch_err(fetch_err)
  );

  // PC register block as seen by the sequencer.
  always @(posedge clk) begin
    if (env_init) pc <= 16'h3000;
    else if (ld_pc) begin
      case (pc_sel)
        2'b00:   pc <= pc + 16'd1;
        2'b01:   pc <= bus_val;
        2'b10:   pc <= ea_val;
        default: pc <= 16'hDEAD;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_ld_pc"}, ld_pc, 0);
    chk({tag, "_ir_valid"}, ir_valid, 0);
    chk({tag, "_ack"}, redirect_ack, 0);
    chk({tag, "_fetch_err"}, fetch_err, 0);
    chk({tag, "_ir"}, ir, last_ir);
    chk({tag, "_pc"}, pc, arch_pc);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_ld_pc"}, ld_pc, 0);
    chk({tag, "_pc_sel"}, pc_sel, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_ir"}, ir, 0);
    chk({tag, "_ir_valid"}, ir_valid, 0);
    chk({tag, "_ack"}, redirect_ack, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fetch_err"}, fetch_err, 0);
  endtask

  // One instruction fetch with 'lat' wait cycles; noise on ignored inputs.
  task automatic do_fetch(input int lat, input logic [15:0] word, input bit hold);
    fetch_start    = 1'b1;
    redirect_valid = 1'b0;
    mem_ready      = 1'($urandom_range(0, 1));
    mem_rdata      = 16'($urandom);
    tick();
    for (int k = 0; k <= lat; k++) begin
      chk("wait_mem_en", mem_en, 1);
      chk("wait_addr", mem_addr, arch_pc);
      chk("wait_ld_pc", ld_pc, 0);
      chk("wait_busy", busy, 1);
      chk("wait_fetch_err", fetch_err, 0);
      fetch_start    = 1'($urandom_range(0, 1));
      redirect_valid = 1'($urandom_range(0, 1));
      redirect_sel   = 1'($urandom_range(0, 1));
      mem_ready      = (k == lat);
      mem_rdata      = (k == lat) ? word : 16'($urandom);
      tick();
    end
    chk("done_ir_valid", ir_valid, 1);
    chk("done_ir", ir, word);
    chk("done_ld_pc", ld_pc, 1);
    chk("done_pc_sel", pc_sel, 0);
    chk("done_mem_en", mem_en, 0);
    chk("done_ack", redirect_ack, 0);
    fetch_start    = hold;
    redirect_valid = 1'b0;
    mem_ready      = 1'($urandom_range(0, 1));
    mem_rdata      = 16'($urandom);
    tick();
    arch_pc = arch_pc + 16'd1;
    last_ir = word;
    check_idle("fetch_idle");
  endtask

  // Redirect to 'tgt' via bus (sel=0) or EA (sel=1), optionally with fetch_start high.
  task automatic do_redirect(input bit sel, input bit also_fetch, input logic [15:0] tgt);
    bus_val        = sel ? ~tgt : tgt;
    ea_val         = sel ? tgt : ~tgt;
    redirect_valid = 1'b1;
    redirect_sel   = sel;
    fetch_start    = also_fetch;
    mem_ready      = 1'($urandom_range(0, 1));
    mem_rdata      = 16'($urandom);
    tick();
    chk("redir_ld_pc", ld_pc, 1);
    chk("redir_pc_sel", pc_sel, sel ? 2 : 1);
    chk("redir_ack", redirect_ack, 1);
    chk("redir_mem_en", mem_en, 0);
    chk("redir_ir_valid", ir_valid, 0);
    chk("redir_busy", busy, 1);
    redirect_valid = 1'b0;
    redirect_sel   = ~sel;
    mem_ready      = 1'($urandom_range(0, 1));
    tick();
    arch_pc = tgt;
    check_idle("redir_idle");
  endtask

  task automatic do_reset_mid_wait(input int pre);
    fetch_start    = 1'b1;
    redirect_valid = 1'b0;
    mem_ready      = 1'b0;
    tick();
    fetch_start = 1'b0;
    for (int k = 0; k < pre; k++) begin
      chk("rstw_mem_en", mem_en, 1);
      tick();
    end
    rst_n = 1'b0;
    tick();
    check_reset_vals("rstw");
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mem_rdata = 16'($urandom);
      tick();
      chk("rstw_late_ir", ir, 0);
      chk("rstw_late_ld_pc", ld_pc, 0);
      chk("rstw_late_busy", busy, 0);
    end
    mem_ready = 1'b0;
    last_ir   = 16'h0000;
    chk("rstw_pc", pc, arch_pc);
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic do_timeout();
    fetch_start    = 1'b1;
    redirect_valid = 1'b0;
    mem_ready      = 1'b0;
    tick();
    fetch_start = 1'b0;
    for (int k = 0; k < TO; k++) begin
      chk("to_mem_en", mem_en, 1);
      chk("to_fetch_err_early", fetch_err, 0);
      tick();
    end
    chk("to_fetch_err", fetch_err, 1);
    chk("to_busy", busy, 0);
    chk("to_mem_en_drop", mem_en, 0);
    chk("to_ld_pc", ld_pc, 0);
    chk("to_ir", ir, last_ir);
    tick();
    check_idle("to_after");
  endtask
`endif

  initial begin
    int max_lat;
`ifdef FETCH_TIMEOUT_EN
    max_lat = TO - 1;
`else
    max_lat = 24;
`endif
    rst_n = 1'b0; env_init = 1'b1;
    fetch_start = 1'b0; redirect_valid = 1'b0; redirect_sel = 1'b0;
    mem_ready = 1'b0; mem_rdata = 16'h0000; bus_val = 16'h0; ea_val = 16'h0;
    tick();
    tick();
    check_reset_vals("reset");
    env_init = 1'b0;
    rst_n    = 1'b1;
    arch_pc  = 16'h3000;
    last_ir  = 16'h0000;
    tick();
    check_idle("post_reset");

    do_fetch(0, 16'h1234, 1'b0);
    do_fetch(5, 16'($urandom), 1'b0);
    do_redirect(1'b1, 1'b1, 16'($urandom));
    do_fetch(1, 16'($urandom), 1'b1);
    do_fetch(3, 16'($urandom), 1'b0);
    do_redirect(1'b0, 1'b0, 16'($urandom));
    do_redirect(1'b0, 1'b0, 16'hFFFF);
    do_fetch(2, 16'($urandom), 1'b0);
    chk("wrap_pc", pc, 16'h0000);
    do_fetch(max_lat, 16'($urandom), 1'b0);
    do_reset_mid_wait(3);
`ifdef FETCH_TIMEOUT_EN
    do_timeout();
`endif

    for (int i = 0; i < 60; i++) begin
      int op;
      int lat;
      op  = int'($urandom_range(0, 9));
      lat = ($urandom_range(0, 7) == 0) ? max_lat : int'($urandom_range(0, 4));
      if (op <= 5)      do_fetch(lat, 16'($urandom), 1'($urandom_range(0, 1)));
      else if (op <= 7) do_redirect(1'($urandom_range(0, 1)), 1'b0, 16'($urandom));
      else if (op == 8) do_redirect(1'($urandom_range(0, 1)), 1'b1, 16'($urandom));
      else              do_reset_mid_wait(int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
